// File: rtl/alu_addsub_p_if.sv
// Operand/result bundle for the decimal floating-point add/subtract unit.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// the producer holds its data stable while valid is high and ready is low.
interface alu_addsub_p_if #(
    parameter int NUM_DIGITS = 8,
    parameter int EXP_WIDTH  = 8
);
    logic                    a_sign_i;
    logic                    b_sign_i;
    logic [EXP_WIDTH-1:0]    a_exp_i;
    logic [EXP_WIDTH-1:0]    b_exp_i;
    logic [4*NUM_DIGITS-1:0] a_sig_i;
    logic [4*NUM_DIGITS-1:0] b_sig_i;
    logic                    a_err_i;
    logic                    b_err_i;
    logic                    op_i;
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic                    res_sign_o;
    logic [EXP_WIDTH-1:0]    res_exp_o;
    logic [4*NUM_DIGITS-1:0] res_sig_o;
    logic                    res_err_o;
    logic                    out_valid_o;
    logic                    out_ready_i;

    modport slave (
        input  a_sign_i, b_sign_i, a_exp_i, b_exp_i, a_sig_i, b_sig_i,
        input  a_err_i, b_err_i, op_i, in_valid_i, out_ready_i,
        output in_ready_o, res_sign_o, res_exp_o, res_sig_o, res_err_o, out_valid_o
    );

    modport master (
        output a_sign_i, b_sign_i, a_exp_i, b_exp_i, a_sig_i, b_sig_i,
        output a_err_i, b_err_i, op_i, in_valid_i, out_ready_i,
        input  in_ready_o, res_sign_o, res_exp_o, res_sig_o, res_err_o, out_valid_o
    );
endinterface

// File: rtl/alu_addsub_p.sv
// Digit-serial BCD floating-point adder/subtractor: align, add one digit per
// cycle, normalise, round half away from zero, then present a registered result.
module alu_addsub_p #(
    parameter int NUM_DIGITS = 8,
    parameter int EXP_WIDTH  = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    alu_addsub_p_if.slave bus,
    output logic [2:0]    dbg_state_o
);
    localparam int SW = 4 * NUM_DIGITS;
    localparam int XW = SW + 4;
    localparam int RW = XW + 4;
    localparam int IW = $clog2(NUM_DIGITS + 2);
    localparam logic [EXP_WIDTH:0] DMAX    = (EXP_WIDTH+1)'(NUM_DIGITS + 1);
    localparam logic [SW-1:0]      OVF_SIG = SW'(1) << (4 * (NUM_DIGITS - 1));

    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [XW-1:0]         a_x_q, a_x_d, b_x_q, b_x_d;
    logic [EXP_WIDTH-1:0]  a_exp_q, a_exp_d, b_exp_q, b_exp_d;
    logic                  a_sign_q, a_sign_d, b_sign_q, b_sign_d;
    logic                  a_ge_q, a_ge_d, cy_q, cy_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [RW-1:0]         r_q, r_d;
    logic                  res_sign_q, res_sign_d, res_err_q, res_err_d;
    logic [EXP_WIDTH-1:0]  res_exp_q, res_exp_d;
    logic [SW-1:0]         res_sig_q, res_sig_d;

    logic [3:0]            da, db, dig;
    logic [4:0]            s5, lhs, rhs;
    logic                  cy_new;
    logic [SW-1:0]         rnd_sig, fin_sig;
    logic                  rnd_c, fin_err;
    logic [EXP_WIDTH-1:0]  fin_exp, d_exp;

    assign bus.in_ready_o  = (state_q == S_IDLE);
    assign bus.out_valid_o = (state_q == S_DONE);
    assign bus.res_sign_o  = res_sign_q;
    assign bus.res_exp_o   = res_exp_q;
    assign bus.res_sig_o   = res_sig_q;
    assign bus.res_err_o   = res_err_q;
    assign dbg_state_o     = state_q;

    // One digit of the running sum/difference; subtraction is always larger minus smaller.
    always_comb begin
        da     = a_x_q[4*idx_q +: 4];
        db     = b_x_q[4*idx_q +: 4];
        dig    = 4'h0;
        cy_new = 1'b0;
        s5     = '0;
        lhs    = '0;
        rhs    = '0;
        if (a_sign_q == b_sign_q) begin
            s5 = {1'b0, da} + {1'b0, db} + {4'b0, cy_q};
            if (s5 >= 5'd10) begin
                dig    = 4'(s5 - 5'd10);
                cy_new = 1'b1;
            end else begin
                dig = s5[3:0];
            end
        end else begin
            lhs = a_ge_q ? {1'b0, da} : {1'b0, db};
            rhs = (a_ge_q ? {1'b0, db} : {1'b0, da}) + {4'b0, cy_q};
            if (lhs < rhs) begin
                dig    = 4'(lhs + 5'd10 - rhs);
                cy_new = 1'b1;
            end else begin
                dig = 4'(lhs - rhs);
            end
        end
    end

    // BCD increment of the significand; rnd_c set means it was all nines.
    always_comb begin
        rnd_sig = r_q[XW-1:4];
        rnd_c   = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (rnd_c) begin
                if (r_q[4*(i+1) +: 4] == 4'd9) begin
                    rnd_sig[4*i +: 4] = 4'd0;
                end else begin
                    rnd_sig[4*i +: 4] = r_q[4*(i+1) +: 4] + 4'd1;
                    rnd_c = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        a_x_d      = a_x_q;
        b_x_d      = b_x_q;
        a_exp_d    = a_exp_q;
        b_exp_d    = b_exp_q;
        a_sign_d   = a_sign_q;
        b_sign_d   = b_sign_q;
        a_ge_d     = a_ge_q;
        cy_d       = cy_q;
        idx_d      = idx_q;
        r_d        = r_q;
        res_sign_d = res_sign_q;
        res_exp_d  = res_exp_q;
        res_sig_d  = res_sig_q;
        res_err_d  = res_err_q;
        fin_sig    = r_q[XW-1:4];
        fin_exp    = a_exp_q;
        fin_err    = 1'b0;
        d_exp      = (a_exp_q > b_exp_q) ? (a_exp_q - b_exp_q) : (b_exp_q - a_exp_q);

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid_i) begin
                    a_x_d    = {bus.a_sig_i, 4'h0};
                    b_x_d    = {bus.b_sig_i, 4'h0};
                    a_exp_d  = bus.a_exp_i;
                    b_exp_d  = bus.b_exp_i;
                    a_sign_d = bus.a_sign_i;
                    b_sign_d = bus.b_sign_i ^ bus.op_i;
                    if (bus.a_err_i || bus.b_err_i) begin
                        res_err_d  = 1'b1;
                        res_sign_d = 1'b0;
                        res_exp_d  = '0;
                        res_sig_d  = '0;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_ALIGN;
                    end
                end
            end
            S_ALIGN: begin
                if (a_exp_q == b_exp_q) begin
                    a_ge_d  = (a_x_q >= b_x_q);
                    idx_d   = '0;
                    cy_d    = 1'b0;
                    r_d     = '0;
                    state_d = S_ADD;
                end else if (a_exp_q > b_exp_q) begin
                    if ({1'b0, d_exp} > DMAX) begin
                        b_x_d   = '0;
                        b_exp_d = a_exp_q;
                    end else begin
                        b_x_d   = b_x_q >> 4;
                        b_exp_d = b_exp_q + EXP_WIDTH'(1);
                    end
                end else begin
                    if ({1'b0, d_exp} > DMAX) begin
                        a_x_d   = '0;
                        a_exp_d = b_exp_q;
                    end else begin
                        a_x_d   = a_x_q >> 4;
                        a_exp_d = a_exp_q + EXP_WIDTH'(1);
                    end
                end
            end
            S_ADD: begin
                r_d[4*idx_q +: 4] = dig;
                cy_d  = cy_new;
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(NUM_DIGITS)) begin
                    r_d[RW-1 -: 4] = (a_sign_q == b_sign_q) ? {3'b0, cy_new} : 4'h0;
                    state_d        = S_NORM;
                end
            end
            S_NORM: begin
                if (r_q[RW-1 -: 4] != 4'h0) begin
                    if (&a_exp_q) begin
                        res_err_d  = 1'b1;
                        res_sign_d = 1'b0;
                        res_exp_d  = '0;
                        res_sig_d  = '0;
                        state_d    = S_DONE;
                    end else begin
                        r_d     = r_q >> 4;
                        a_exp_d = a_exp_q + EXP_WIDTH'(1);
                    end
                end else if (a_exp_q != '0 && r_q[XW-1 -: 4] == 4'h0 && r_q[XW-1:0] != '0) begin
                    r_d     = {4'h0, r_q[XW-5:0], 4'h0};
                    a_exp_d = a_exp_q - EXP_WIDTH'(1);
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (r_q[3:0] >= 4'd5) begin
                    if (!rnd_c) begin
                        fin_sig = rnd_sig;
                    end else if (&a_exp_q) begin
                        fin_err = 1'b1;
                    end else begin
                        fin_sig = OVF_SIG;
                        fin_exp = a_exp_q + EXP_WIDTH'(1);
                    end
                end
                res_err_d = fin_err;
                if (fin_err || fin_sig == '0) begin
                    res_sign_d = 1'b0;
                    res_exp_d  = '0;
                    res_sig_d  = '0;
                end else begin
                    res_sign_d = a_ge_q ? a_sign_q : b_sign_q;
                    res_exp_d  = fin_exp;
                    res_sig_d  = fin_sig;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            a_x_q      <= '0;
            b_x_q      <= '0;
            a_exp_q    <= '0;
            b_exp_q    <= '0;
            a_sign_q   <= 1'b0;
            b_sign_q   <= 1'b0;
            a_ge_q     <= 1'b0;
            cy_q       <= 1'b0;
            idx_q      <= '0;
            r_q        <= '0;
            res_sign_q <= 1'b0;
            res_exp_q  <= '0;
            res_sig_q  <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_x_q      <= a_x_d;
            b_x_q      <= b_x_d;
            a_exp_q    <= a_exp_d;
            b_exp_q    <= b_exp_d;
            a_sign_q   <= a_sign_d;
            b_sign_q   <= b_sign_d;
            a_ge_q     <= a_ge_d;
            cy_q       <= cy_d;
            idx_q      <= idx_d;
            r_q        <= r_d;
            res_sign_q <= res_sign_d;
            res_exp_q  <= res_exp_d;
            res_sig_q  <= res_sig_d;
            res_err_q  <= res_err_d;
        end
    end
endmodule

// File: tb/tb_alu_addsub_p.sv
// Directed and lightly randomised checks of alu_addsub_p with 4-digit operands
// and 4-bit exponents; results are scored against an expected queue.
module tb_alu_addsub_p;
    localparam int ND = 4;
    localparam int EW = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    alu_addsub_p_if #(.NUM_DIGITS(ND), .EXP_WIDTH(EW)) bus ();

    alu_addsub_p #(.NUM_DIGITS(ND), .EXP_WIDTH(EW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    int          checks = 0;
    int          errors = 0;
    logic [21:0] exp_q[$];

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] b;
        int          t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            b[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return b;
    endfunction

    function automatic logic [21:0] pack(input logic err, input logic sgn, input int e, input int sig);
        return {err, sgn, 4'(e), to_bcd(sig)};
    endfunction

    function automatic logic [21:0] res_now();
        return {bus.res_err_o, bus.res_sign_o, bus.res_exp_o, bus.res_sig_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic as, input int ae, input int av, input logic bs, input int be,
                         input int bv, input logic aerr, input logic berr, input logic op);
        bus.a_sign_i   = as;
        bus.a_exp_i    = 4'(ae);
        bus.a_sig_i    = to_bcd(av);
        bus.b_sign_i   = bs;
        bus.b_exp_i    = 4'(be);
        bus.b_sig_i    = to_bcd(bv);
        bus.a_err_i    = aerr;
        bus.b_err_i    = berr;
        bus.op_i       = op;
        bus.in_valid_i = 1'b1;
    endtask

    // Called at a negedge; returns at a negedge with the DUT back in IDLE.
    task automatic run_op(input string tag, input logic as, input int ae, input int av,
                          input logic bs, input int be, input int bv, input logic aerr,
                          input logic berr, input logic op, input logic [21:0] expv,
                          input int exp_lat, input int hold);
        int          lat;
        int          n;
        bit          seen;
        logic [21:0] got;
        logic [21:0] want;
        exp_q.push_back(expv);
        drive(as, ae, av, bs, be, bv, aerr, berr, op);
        n = 0;
        while (!bus.in_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " in_ready"}, 32'(bus.in_ready_o), 32'd1);
        @(posedge clk);
        #1 bus.in_valid_i = 1'b0;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.out_valid_o) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        chk({tag, " seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        got  = res_now();
        want = exp_q.pop_front();
        chk({tag, " result"}, 32'(got), 32'(want));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold res"}, 32'(res_now()), 32'(want));
            chk({tag, " hold ready"}, {bus.in_ready_o, bus.out_valid_o}, 32'b01);
        end
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1 bus.out_ready_i = 1'b0;
        @(negedge clk);
        chk({tag, " back idle"}, {bus.in_ready_o, bus.out_valid_o}, 32'b10);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  av, bv, dv;
        bit  late_valid;
        rst_n           = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        drive(1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        bus.in_valid_i  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset handshake", {bus.in_ready_o, bus.out_valid_o}, 32'b10);
        chk("reset result", 32'(res_now()), 32'd0);
        chk("reset state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("basic_add", 0, 0, 1234, 0, 0, 5678, 0, 0, 0, pack(0, 0, 0, 6912), 8, 0);
        run_op("carry_round", 0, 0, 9999, 0, 0, 6, 0, 0, 0, pack(0, 0, 1, 1001), 9, 0);
        run_op("sub_leftnorm", 0, 1, 1000, 0, 0, 9999, 0, 0, 1, pack(0, 0, 0, 1), 10, 0);
        run_op("sub_zero", 0, 3, 1234, 0, 3, 1234, 0, 0, 1, pack(0, 0, 0, 0), 8, 0);
        run_op("sub_neg", 0, 0, 1000, 0, 0, 2000, 0, 0, 1, pack(0, 1, 0, 1000), 8, 0);
        run_op("exp_wrap", 0, 15, 9999, 0, 15, 9999, 0, 0, 0, pack(1, 0, 0, 0), 7, 0);
        run_op("a_err_hold", 1, 7, 4321, 0, 2, 1111, 1, 0, 0, pack(1, 0, 0, 0), 0, 5);
        run_op("b_err", 0, 1, 1000, 1, 9, 2222, 0, 1, 1, pack(1, 0, 0, 0), 0, 0);
        run_op("round_ovf", 0, 1, 9998, 0, 0, 15, 0, 0, 0, pack(0, 0, 2, 1000), 9, 0);
        run_op("align4_round", 0, 4, 1000, 0, 0, 5000, 0, 0, 0, pack(0, 0, 4, 1001), 12, 0);
        run_op("align5_drop", 0, 5, 1000, 0, 0, 9999, 0, 0, 0, pack(0, 0, 5, 1000), 13, 0);
        run_op("align_far", 0, 9, 5000, 0, 0, 1234, 0, 0, 0, pack(0, 0, 9, 5000), 9, 0);
        run_op("neg_add", 1, 0, 1234, 1, 0, 766, 0, 0, 0, pack(0, 1, 0, 2000), 8, 0);
        run_op("sub_negb", 0, 0, 100, 1, 0, 5, 0, 0, 1, pack(0, 0, 0, 105), 8, 0);

        for (int k = 0; k < 4; k++) begin
            av = int'($urandom_range(0, 4999));
            bv = int'($urandom_range(0, 4999));
            run_op("rand_add", 0, 0, av, 0, 0, bv, 0, 0, 0, pack(0, 0, 0, av + bv), 8, 0);
        end
        for (int k = 0; k < 4; k++) begin
            av = int'($urandom_range(0, 9999));
            bv = int'($urandom_range(0, 9999));
            dv = (av >= bv) ? av - bv : bv - av;
            run_op("rand_sub", 0, 0, av, 0, 0, bv, 0, 0, 1, pack(0, (av < bv), 0, dv), 8, 0);
        end

        // Abort an operation in the middle of the digit-serial add.
        drive(0, 0, 1234, 0, 0, 5678, 0, 0, 0);
        @(posedge clk);
        #1 bus.in_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset handshake", {bus.in_ready_o, bus.out_valid_o}, 32'b10);
        chk("mid_reset result", 32'(res_now()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        late_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid_o) late_valid = 1'b1;
        end
        chk("mid_reset no output", 32'(late_valid), 32'd0);
        run_op("after_reset", 0, 0, 1234, 0, 0, 5678, 0, 0, 0, pack(0, 0, 0, 6912), 8, 0);

        chk("queue drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_addsub_p.md
ALU_ADDSUB_P -- requirements
Module: alu_addsub_p

Interface
REQ-001 Parameter NUM_DIGITS, default 8: BCD significand digits per operand (>=2).
REQ-002 Parameter EXP_WIDTH, default 8: unsigned exponent width; value = sign * significand * 10^exponent.
REQ-003 clk_i  in  1  sole clock, rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 a_sign_i, b_sign_i  in  1 each  operand sign (1 = negative).
REQ-006 a_exp_i, b_exp_i  in  EXP_WIDTH each  operand exponent.
REQ-007 a_sig_i, b_sig_i  in  4*NUM_DIGITS each  BCD significand, digit 0 in bits [3:0].
REQ-008 a_err_i, b_err_i  in  1 each  operand carries error.
REQ-009 op_i  in  1  0 = A+B, 1 = A-B.
REQ-010 in_valid_i  in  1 / in_ready_o  out  1  input handshake.
REQ-011 res_sign_o  out  1; res_exp_o  out  EXP_WIDTH; res_sig_o  out  4*NUM_DIGITS; res_err_o  out  1  result.
REQ-012 out_valid_o  out  1 / out_ready_i  in  1  output handshake.

Function
REQ-013 States IDLE, ALIGN, ADD, NORM, ROUND, DONE; in_ready_o = 1 only in IDLE; out_valid_o = 1 only in DONE.
REQ-014 IDLE: on in_valid_i=1, capture all operand fields, effective B sign = b_sign_i XOR op_i, -> ALIGN.
REQ-015 Either operand error flag set at capture: -> DONE directly with res_err_o=1, sig 0, sign 0, exp 0.
REQ-016 Internal operands extended to NUM_DIGITS+1 digits (guard digit below digit 0, initially 0).
REQ-017 ALIGN, exponent difference d in 1..NUM_DIGITS+1: shift smaller-exponent operand right one digit per cycle into guard, exponent +1.
REQ-018 ALIGN, d > NUM_DIGITS+1: smaller operand zeroed and exponent equalised in one cycle.
REQ-019 ALIGN, exponents equal: one cycle registering magnitude compare (A>=B) of extended significands, -> ADD.
REQ-020 ADD: one extended digit per cycle, guard first, NUM_DIGITS+1 cycles; same effective signs: BCD add with carry (digit sum >=10 -> +6); else larger minus smaller with borrow (negative digit -> +10).
REQ-021 Result sign = sign of larger magnitude; A on tie; final carry out kept as extra digit.
REQ-022 NORM, one action per cycle, priority: extra digit nonzero -> shift right (extra into MSD, old guard discarded), exp+1; else exp!=0 and MSD=0 and extended significand!=0 -> shift left (guard into digit 0, guard=0), exp-1; else -> ROUND.
REQ-023 Exponent increment wrapping to 0 at any point: res_err_o=1, sig 0, -> DONE.
REQ-024 ROUND (1 cycle): guard>=5 -> magnitude +1 (round half away from zero); if that overflows to 10^NUM_DIGITS: sig = 10^(NUM_DIGITS-1), exp+1 (wrap -> error per REQ-023); guard dropped.
REQ-025 Zero significand after ROUND: sign 0, exp 0.
REQ-026 DONE: result outputs stable while out_valid_o=1; on out_ready_i=1 -> IDLE, in_ready_o=1 next cycle.
REQ-027 Latency, equal exponents, no NORM shift: out_valid_o rises on 8th rising edge after accepting edge; +1 cycle per ALIGN shift and per NORM shift.
REQ-028 Result outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-029 rst_ni=0 asynchronously: state IDLE, in_ready_o=1, out_valid_o=0, all result outputs and internal registers 0, regardless of state.
REQ-030 Reset mid-operation aborts it; no output for that operation appears after reset release.

Verification (NUM_DIGITS=4, EXP_WIDTH=4)
REQ-031 1234e0 + 5678e0, op 0 -> 6912e0, sign 0, err 0, out_valid_o on 8th edge after accept.
REQ-032 9999e0 + 0006e0 -> carry, right shift, guard 5 rounds up -> 1001e1.
REQ-033 1000e1 - 9999e0 (op 1) -> align 0999|9, diff 0000|1, left shift to exp 0 -> 0001e0, sign 0.
REQ-034 1234e3 - 1234e3 (op 1) -> 0000e0, sign 0; 1000e0 - 2000e0 -> 1000e0, sign 1.
REQ-035 9999e15 + 9999e15 -> res_err_o=1; a_err_i=1 with any B -> res_err_o=1 without ALIGN/ADD; out_ready_i=0 for 5 cycles -> outputs held, in_ready_o=0.
REQ-036 rst_ni pulsed low during ADD -> in_ready_o=1, out_valid_o=0 immediately; next operation 1234e0+5678e0 -> 6912e0.
